// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing a bank of PPC-writable 32-bit control registers
// to fabric logic, with byte enables, readback, strobes and triggers.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01003000,
    parameter logic [31:0] C_HIGHADDR   = 32'h010030FF,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [31:0] C_RESET_VAL  = 32'h00000000,
    parameter logic [15:0] C_PULSE_MASK = 16'h0000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter logic [63:0] C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:31]             OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:31]             OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:31]             Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]   user_wr_strobe
);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] abus;
    logic [31:0] off;
    logic [3:0]  idx;
    logic        hit;
    logic        start;
    logic        do_wr;
    logic [31:0] rd_word;

    logic [3:0]  cap_idx;
    logic        cap_rnw;
    logic [3:0]  cap_be;
    logic [31:0] cap_data;

    // OPB bit 0 is the MSB, so the numeric value maps straight across
    assign abus  = OPB_ABus;
    assign off   = abus - C_BASEADDR;
    assign idx   = off[5:2];
    assign hit   = OPB_select
                && (abus >= C_BASEADDR)
                && (abus <= C_HIGHADDR);
    assign start = (state == S_IDLE) && hit;
    assign do_wr = (state == S_ACK) && !cap_rnw;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, off[31:6], off[1:0],
                         C_OPB_AWIDTH[0], C_OPB_DWIDTH[0],
                         C_FAMILY[0]};

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8]
                                  : old_v[8*b +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (hit) state_nxt = S_ACK;
            S_ACK:  state_nxt = S_IDLE;
        endcase
    end

    // Out-of-range indices match no register and read as zero
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < C_NUM_REGS; r++) begin
            if (idx == 4'(r)) begin
                rd_word = user_data_out[32*r +: 32];
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            cap_idx    <= '0;
            cap_rnw    <= 1'b1;
            cap_be     <= '0;
            cap_data   <= '0;
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
        end else begin
            Sl_xferAck <= start;
            Sl_DBus    <= (start && OPB_RNW) ? rd_word : '0;
            if (start) begin
                cap_idx  <= idx;
                cap_rnw  <= OPB_RNW;
                cap_be   <= OPB_BE;
                cap_data <= OPB_DBus;
            end
        end
    end

    // Trigger registers hold a written value for one cycle only
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            user_wr_strobe <= '0;
            for (int r = 0; r < C_NUM_REGS; r++) begin
                user_data_out[32*r +: 32] <=
                    C_PULSE_MASK[r] ? '0 : C_RESET_VAL;
            end
        end else begin
            user_wr_strobe <= '0;
            for (int r = 0; r < C_NUM_REGS; r++) begin
                if (do_wr && cap_idx == 4'(r)) begin
                    user_data_out[32*r +: 32] <=
                        be_merge(user_data_out[32*r +: 32],
                                 cap_data, cap_be);
                    user_wr_strobe[r] <= 1'b1;
                end else if (C_PULSE_MASK[r]) begin
                    user_data_out[32*r +: 32] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Randomised scoreboard bench for the OPB control register bank.
// A driver models the bank and queues expectations; a monitor checks.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE  = 32'h01003000;
    localparam logic [31:0] HIGH  = 32'h010030FF;
    localparam logic [31:0] RVAL  = 32'h12345678;
    localparam logic [15:0] PMASK = 16'h0002;
    localparam int          NREG  = 4;

    logic         OPB_Clk;
    logic         OPB_Rst;
    logic [0:31]  OPB_ABus;
    logic [0:3]   OPB_BE;
    logic [0:31]  OPB_DBus;
    logic         OPB_RNW;
    logic         OPB_select;
    logic         OPB_seqAddr;
    logic [0:31]  Sl_DBus;
    logic         Sl_xferAck;
    logic         Sl_errAck;
    logic         Sl_retry;
    logic         Sl_toutSup;
    logic [127:0] user_data_out;
    logic [3:0]   user_wr_strobe;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_NUM_REGS   (NREG),
        .C_RESET_VAL  (RVAL),
        .C_PULSE_MASK (PMASK)
    ) dut (
        .OPB_Clk        (OPB_Clk),
        .OPB_Rst        (OPB_Rst),
        .OPB_ABus       (OPB_ABus),
        .OPB_BE         (OPB_BE),
        .OPB_DBus       (OPB_DBus),
        .OPB_RNW        (OPB_RNW),
        .OPB_select     (OPB_select),
        .OPB_seqAddr    (OPB_seqAddr),
        .Sl_DBus        (Sl_DBus),
        .Sl_xferAck     (Sl_xferAck),
        .Sl_errAck      (Sl_errAck),
        .Sl_retry       (Sl_retry),
        .Sl_toutSup     (Sl_toutSup),
        .user_data_out  (user_data_out),
        .user_wr_strobe (user_wr_strobe)
    );

    typedef struct {
        logic [31:0]  rdata;
        logic [3:0]   strobe;
        logic [127:0] up;
        logic [127:0] ua;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_reg [NREG];
    int          checks   = 0;
    int          failures = 0;

    initial OPB_Clk = 1'b0;
    always #5 OPB_Clk = ~OPB_Clk;

    task automatic chk(input string name,
                       input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h",
                     name, got, want);
        end
    endtask

    function automatic logic [127:0] pack();
        return {exp_reg[3], exp_reg[2], exp_reg[1], exp_reg[0]};
    endfunction

    function automatic logic [127:0] reset_img();
        logic [127:0] v;
        for (int r = 0; r < NREG; r++)
            v[32*r +: 32] = PMASK[r] ? 32'h0 : RVAL;
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++)
            exp_reg[r] = PMASK[r] ? 32'h0 : RVAL;
    endtask

    // Monitor: checks strobe/data every cycle, read data on acks
    exp_t pend;
    bit   have_pend;
    logic [127:0] steady;

    initial begin
        have_pend   = 1'b1;
        pend.rdata  = '0;
        pend.strobe = '0;
        pend.up     = reset_img();
        pend.ua     = reset_img();
        steady      = reset_img();
    end

    always @(negedge OPB_Clk) begin
        exp_t e;
        if (have_pend) begin
            chk("strobe", user_wr_strobe, pend.strobe);
            chk("uout_upd", user_data_out, pend.up);
            steady    = pend.ua;
            have_pend = 1'b0;
        end else begin
            chk("strobe_idle", user_wr_strobe, 4'h0);
            chk("uout_hold", user_data_out, steady);
        end
        if (Sl_xferAck) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: got ack expected none");
            end else begin
                e = q.pop_front();
                chk("rdata", Sl_DBus, e.rdata);
                pend      = e;
                have_pend = 1'b1;
            end
        end else begin
            chk("dbus_idle", Sl_DBus, 32'h0);
        end
        if (OPB_Rst) begin
            pend.rdata  = '0;
            pend.strobe = '0;
            pend.up     = reset_img();
            pend.ua     = reset_img();
            have_pend   = 1'b1;
        end
    end

    task automatic issue(input logic [31:0] addr,
                         input logic rnw,
                         input logic [3:0] be,
                         input logic [31:0] data);
        exp_t        e;
        int          ix;
        logic [31:0] m;
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_BE     = be;
        OPB_DBus   = data;
        OPB_select = 1'b1;
        if (addr >= BASE && addr <= HIGH) begin
            ix       = int'((addr - BASE) / 4) % 16;
            e.rdata  = '0;
            e.strobe = '0;
            if (rnw) begin
                if (ix < NREG) e.rdata = exp_reg[ix];
            end else if (ix < NREG) begin
                for (int b = 0; b < 4; b++)
                    m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
                exp_reg[ix] = (exp_reg[ix] & ~m) | (data & m);
                e.strobe    = 4'(1 << ix);
            end
            e.up = pack();
            if (!rnw && ix < NREG && PMASK[ix])
                exp_reg[ix] = 32'h0;
            e.ua = pack();
            q.push_back(e);
        end
    endtask

    task automatic wait_ack(input int lat, input string name);
        int n = 0;
        do begin
            @(posedge OPB_Clk);
            #1;
            n++;
        end while (!Sl_xferAck && n < 20);
        chk($sformatf("%s_latency", name), 128'(n), 128'(lat));
    endtask

    task automatic xfer(input logic [31:0] addr,
                        input logic rnw,
                        input logic [3:0] be,
                        input logic [31:0] data,
                        input string name);
        issue(addr, rnw, be, data);
        wait_ack(1, name);
        OPB_select = 1'b0;
        repeat (2) @(posedge OPB_Clk);
        #1;
    endtask

    task automatic nohit(input logic [31:0] addr, input logic rnw);
        bit seen = 1'b0;
        issue(addr, rnw, 4'hF, $urandom);
        repeat (10) begin
            @(posedge OPB_Clk);
            #1;
            if (Sl_xferAck) seen = 1'b1;
        end
        chk("nohit_ack", 128'(seen), 128'(0));
        OPB_select = 1'b0;
        @(posedge OPB_Clk);
        #1;
    endtask

    initial begin
        OPB_Rst     = 1'b1;
        OPB_ABus    = '0;
        OPB_BE      = '0;
        OPB_DBus    = '0;
        OPB_RNW     = 1'b1;
        OPB_select  = 1'b0;
        OPB_seqAddr = 1'b0;
        model_reset();
        repeat (3) @(posedge OPB_Clk);
        #1;
        OPB_Rst = 1'b0;
        @(posedge OPB_Clk);
        #1;

        xfer(BASE + 32'h8, 1'b0, 4'hF, 32'hDEADBEEF, "wr_full");
        xfer(BASE + 32'h8, 1'b1, 4'hF, 32'h0, "rd_full");
        xfer(BASE + 32'h8, 1'b0, 4'b0100, 32'h00AA0000, "wr_be");
        xfer(BASE + 32'h8, 1'b1, 4'hF, 32'h0, "rd_be");
        xfer(BASE + 32'h0, 1'b1, 4'hF, 32'h0, "rd_r0");
        xfer(BASE + 32'h1C, 1'b1, 4'hF, 32'h0, "rd_oor");
        xfer(BASE + 32'h14, 1'b0, 4'hF, 32'hFFFF0000, "wr_oor");
        nohit(32'h01004000, 1'b1);
        nohit(32'h01004000, 1'b0);
        xfer(BASE + 32'h4, 1'b0, 4'hF, 32'h1, "wr_pulse");
        xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, "rd_pulse");

        issue(BASE + 32'h0, 1'b0, 4'hF, 32'hA0A0A0A0);
        wait_ack(1, "burst0");
        issue(BASE + 32'h4, 1'b0, 4'hF, 32'hB1B1B1B1);
        wait_ack(2, "burst1");
        issue(BASE + 32'h8, 1'b0, 4'hF, 32'hC2C2C2C2);
        wait_ack(2, "burst2");
        issue(BASE + 32'hC, 1'b0, 4'hF, 32'hD3D3D3D3);
        wait_ack(2, "burst3");
        OPB_select = 1'b0;
        repeat (2) @(posedge OPB_Clk);
        #1;
        for (int r = 0; r < NREG; r++)
            xfer(BASE + 32'(4 * r), 1'b1, 4'hF, 32'h0, "rd_burst");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                nohit($urandom_range(0, 1) ? 32'h01004000
                                           : 32'h01002FFC,
                      1'($urandom_range(0, 1)));
            end else begin
                xfer(BASE + 32'(4 * $urandom_range(0, 7)),
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) ? 4'hF
                                          : 4'($urandom_range(0, 15)),
                     $urandom, "rand");
            end
        end

        issue(BASE + 32'h8, 1'b0, 4'hF, 32'hFFFFFFFF);
        wait_ack(1, "wr_rst");
        OPB_select = 1'b0;
        OPB_Rst    = 1'b1;
        @(posedge OPB_Clk);
        #1;
        OPB_Rst = 1'b0;
        model_reset();
        repeat (3) @(posedge OPB_Clk);
        #1;
        for (int r = 0; r < NREG; r++)
            xfer(BASE + 32'(4 * r), 1'b1, 4'hF, 32'h0, "rd_rst");

        repeat (5) @(posedge OPB_Clk);
        #1;
        chk("queue_empty", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
